// File: rtl/lsq_mem_pkg.sv
// Shared types for the LSQ memory responder: request bundle, FSM states
// and read/write encodings.
package lsq_mem_pkg;

  localparam int PKG_ID_W = 4;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic                rw;
    logic [31:0]         addr;
    logic [31:0]         wdata;
    logic [PKG_ID_W-1:0] id;
  } mem_req_t;

endpackage

// File: rtl/lsq_mem_req_fifo.sv
// In-order request queue of mem_req_t.
// Ports: push_i/din_i in, pop_i/dout_o out (head shown combinationally),
// full_o/empty_o/count_o status from registered occupancy.
module lsq_mem_req_fifo
  import lsq_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  mem_req_t                 din_i,
  input  logic                     pop_i,
  output mem_req_t                 dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  mem_req_t      ent_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = ent_q[rptr_q];

  // Full blocks a push even if a pop frees a slot on the same edge.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q + PW'(do_push);
    rptr_d = rptr_q + PW'(do_pop);
    cnt_d  = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) ent_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/lsq_mem_responder.sv
// Memory-side responder for the LSQ port: queues requests in order and
// serves each against a word array after a fixed latency, returning a
// tagged one-cycle ready pulse. Optional miss timing via
// DMEM_MISS_MODEL_EN (direct-mapped tag/valid array, timing only).
// Ports: valid_in/rw_in/addr_in/wdata_in/ldstID_in request in;
// stall_out queue full; rdata_out/ldstID_out/ready_out completion out.
module lsq_mem_responder
  import lsq_mem_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int ID_W     = PKG_ID_W,
  parameter int QDEPTH   = 4,
  parameter int LAT      = 2,
  parameter int MISS_LAT = 6,
  parameter int NLINES   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic            rw_in,
  input  logic [31:0]     addr_in,
  input  logic [31:0]     wdata_in,
  input  logic [ID_W-1:0] ldstID_in,
  output logic            stall_out,
  output logic [31:0]     rdata_out,
  output logic [ID_W-1:0] ldstID_out,
  output logic            ready_out
);

  localparam int CNT_W = $clog2(LAT + MISS_LAT + 1);
  localparam logic [CNT_W-1:0] HIT_LOAD  = CNT_W'(LAT - 1);
  localparam logic [CNT_W-1:0] MISS_LOAD = CNT_W'(LAT + MISS_LAT - 1);

  mem_req_t fifo_din, fifo_dout;
  logic     fifo_full, fifo_empty;
  logic [$clog2(QDEPTH):0] fifo_count_unused;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, load_cnt;
  mem_req_t         cur_q, cur_d;
  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             complete, pop, mem_we;
  logic [ADDR_W-1:0] cur_idx;
  logic [31:0]      mem_q [2**ADDR_W];
  logic             unused_addr;

  assign fifo_din = '{
    rw:    rw_in,
    addr:  addr_in,
    wdata: wdata_in,
    id:    PKG_ID_W'(ldstID_in)
  };

  lsq_mem_req_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (valid_in),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_unused)
  );

  assign cur_idx     = cur_q.addr[ADDR_W+1:2];
  assign unused_addr = ^{cur_q.addr[31:ADDR_W+2], cur_q.addr[1:0]};

  assign stall_out  = fifo_full;
  assign ready_out  = ready_q;
  assign rdata_out  = rdata_q;
  assign ldstID_out = id_q;

  assign complete = (state_q == BUSY) && (cnt_q == '0);
  assign pop      = !fifo_empty && ((state_q == IDLE) || complete);
  assign mem_we   = complete && (cur_q.rw == RW_WRITE) && !rst;

`ifdef DMEM_MISS_MODEL_EN
  localparam int LW    = $clog2(NLINES);
  localparam int TAG_W = ADDR_W - 2 - LW;

  logic [NLINES-1:0] lv_q, lv_d;
  logic [TAG_W-1:0]  tag_q [NLINES];
  logic [ADDR_W-1:0] head_idx;
  logic [LW-1:0]     head_line;
  logic [TAG_W-1:0]  head_tag;
  logic              hit;
  logic              unused_head;

  assign head_idx    = fifo_dout.addr[ADDR_W+1:2];
  assign head_line   = head_idx[LW+1:2];
  assign head_tag    = head_idx[ADDR_W-1:LW+2];
  assign hit         = lv_q[head_line] && (tag_q[head_line] == head_tag);
  assign unused_head = ^head_idx[1:0];

  always_comb begin
    load_cnt = hit ? HIT_LOAD : MISS_LOAD;
    lv_d     = lv_q;
    if (pop && !hit) lv_d[head_line] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lv_q <= '0;
    else     lv_q <= lv_d;
  end

  always_ff @(posedge clk) begin
    if (pop && !hit) tag_q[head_line] <= head_tag;
  end
`else
  logic [CNT_W-1:0] unused_miss;
  assign unused_miss = MISS_LOAD;
  assign load_cnt    = HIT_LOAD;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    ready_d = 1'b0;
    rdata_d = rdata_q;
    id_d    = id_q;
    if (complete) begin
      ready_d = 1'b1;
      id_d    = ID_W'(cur_q.id);
      rdata_d = (cur_q.rw == RW_WRITE) ? 32'd0 : mem_q[cur_idx];
      state_d = IDLE;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    // A completing edge may immediately start the next request.
    if (pop) begin
      cur_d   = fifo_dout;
      cnt_d   = load_cnt;
      state_d = BUSY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      id_q    <= id_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[cur_idx] <= cur_q.wdata;
  end

endmodule
